// File: rtl/road_pkg.sv
// Shared encodings and default tuning values for the scrolling-road run controller.
package road_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACCEL   = 3'd1;
  localparam logic [2:0] ST_CRUISE  = 3'd2;
  localparam logic [2:0] ST_BRAKE   = 3'd3;
  localparam logic [2:0] ST_PAUSED  = 3'd4;
  localparam logic [2:0] ST_STOPPED = 3'd5;

  localparam logic [7:0]  SPEED_SLOW_DEF  = 8'd200;
  localparam logic [7:0]  SPEED_FAST_DEF  = 8'd20;
  localparam logic [7:0]  SPEED_STEP_DEF  = 8'd10;
  localparam int          RAMP_FRAMES_DEF = 4;
  localparam logic [15:0] SCENE_DIST_DEF  = 16'd1000;
  localparam int          SCENE_COUNT     = 4;

  typedef enum logic {
    DIR_ACCEL = 1'b0,
    DIR_BRAKE = 1'b1
  } ramp_dir_e;

  function automatic logic is_running(input logic [2:0] st);
    return (st == ST_ACCEL) || (st == ST_CRUISE) || (st == ST_BRAKE);
  endfunction

endpackage

// File: rtl/road_ctrl_speed_ramp.sv
// Frame-paced speed ramp: counts frame ticks and steps the divider toward the
// fast or slow limit with saturation.
module road_ctrl_speed_ramp
  import road_pkg::*;
#(
  parameter logic [7:0] SPEED_SLOW  = SPEED_SLOW_DEF,
  parameter logic [7:0] SPEED_FAST  = SPEED_FAST_DEF,
  parameter logic [7:0] SPEED_STEP  = SPEED_STEP_DEF,
  parameter int         RAMP_FRAMES = RAMP_FRAMES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  ramp_dir_e  dir_i,
  input  logic       en_i,
  input  logic       frame_tick_i,
  input  logic       clear_i,
  output logic [7:0] speed_o,
  output logic       at_fast_o,
  output logic       at_slow_o
);

  localparam logic [3:0] CNT_LAST = 4'(RAMP_FRAMES - 1);

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] speed_q, speed_d;
  logic [8:0] dec, inc;
  logic       step;

  // A clear (state change) wins over a pending step, so coincident events never ramp.
  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && frame_tick_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign dec = {1'b0, speed_q} - {1'b0, SPEED_STEP};
  assign inc = {1'b0, speed_q} + {1'b0, SPEED_STEP};

  always_comb begin
    speed_d = speed_q;
    if (step) begin
      if (dir_i == DIR_ACCEL) begin
        speed_d = (dec[8] || (dec[7:0] < SPEED_FAST)) ? SPEED_FAST : dec[7:0];
      end else begin
        speed_d = (inc > {1'b0, SPEED_SLOW}) ? SPEED_SLOW : inc[7:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      speed_q <= SPEED_SLOW;
    end else begin
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
    end
  end

  assign speed_o   = speed_q;
  assign at_fast_o = (speed_q <= SPEED_FAST);
  assign at_slow_o = (speed_q >= SPEED_SLOW);

endmodule

// File: rtl/road_ctrl.sv
// Run sequencer for the road scroller: run/pause/brake FSM, gated step enable,
// distance odometer and scene selection.
module road_ctrl
  import road_pkg::*;
#(
  parameter logic [7:0]  SPEED_SLOW  = SPEED_SLOW_DEF,
  parameter logic [7:0]  SPEED_FAST  = SPEED_FAST_DEF,
  parameter logic [7:0]  SPEED_STEP  = SPEED_STEP_DEF,
  parameter int          RAMP_FRAMES = RAMP_FRAMES_DEF,
  parameter logic [15:0] SCENE_DIST  = SCENE_DIST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        crash,
  input  logic        pause,
  input  logic [4:0]  road_y,
  output logic        road_clk_en,
  output logic [7:0]  speed,
  output logic [1:0]  scene,
  output logic [15:0] distance,
  output logic [2:0]  state_o
);

  logic [2:0]  state_q, state_d, resume_q, resume_d;
  logic        armed_q, armed_d;
  logic [1:0]  scene_q, scene_d;
  logic [15:0] scene_cnt_q, scene_cnt_d;
  logic [15:0] distance_q, distance_d;
  logic [4:0]  road_y_prev_q;
  logic        run, moved, restart, at_fast, at_slow;

  assign run     = is_running(state_q);
  assign moved   = run && (road_y != road_y_prev_q);
  assign restart = (state_q == ST_STOPPED) && (state_d == ST_IDLE);
  // Armed only after start has been seen low while idle.
  assign armed_d = (state_q == ST_IDLE) && !start;

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    case (state_q)
      ST_IDLE:    if (start && armed_q) state_d = ST_ACCEL;
      ST_ACCEL, ST_CRUISE: begin
        if (crash) begin
          state_d = ST_BRAKE;
        end else if (pause) begin
          state_d  = ST_PAUSED;
          resume_d = state_q;
        end else if ((state_q == ST_ACCEL) && at_fast) begin
          state_d = ST_CRUISE;
        end
      end
      ST_PAUSED:  if (!pause) state_d = resume_q;
      ST_BRAKE:   if (at_slow) state_d = ST_STOPPED;
      ST_STOPPED: if (start) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    distance_d  = distance_q;
    scene_cnt_d = scene_cnt_q;
    scene_d     = scene_q;
    if (restart) begin
      distance_d  = '0;
      scene_cnt_d = '0;
      scene_d     = '0;
    end else if (moved) begin
      if (distance_q != 16'hFFFF) distance_d = distance_q + 16'd1;
      if (scene_cnt_q == SCENE_DIST - 16'd1) begin
        scene_cnt_d = '0;
        scene_d     = (scene_q == 2'(SCENE_COUNT - 1)) ? 2'd0 : scene_q + 2'd1;
      end else begin
        scene_cnt_d = scene_cnt_q + 16'd1;
      end
    end
  end

  road_ctrl_speed_ramp #(
    .SPEED_SLOW  (SPEED_SLOW),
    .SPEED_FAST  (SPEED_FAST),
    .SPEED_STEP  (SPEED_STEP),
    .RAMP_FRAMES (RAMP_FRAMES)
  ) u_ramp (
    .clk_i        (clk),
    .rst_i        (rst),
    .dir_i        ((state_q == ST_BRAKE) ? DIR_BRAKE : DIR_ACCEL),
    .en_i         ((state_q == ST_ACCEL) || (state_q == ST_BRAKE)),
    .frame_tick_i (frame_tick),
    .clear_i      (state_d != state_q),
    .speed_o      (speed),
    .at_fast_o    (at_fast),
    .at_slow_o    (at_slow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      resume_q      <= ST_ACCEL;
      armed_q       <= 1'b0;
      scene_q       <= '0;
      scene_cnt_q   <= '0;
      distance_q    <= '0;
      road_y_prev_q <= '0;
    end else begin
      state_q       <= state_d;
      resume_q      <= resume_d;
      armed_q       <= armed_d;
      scene_q       <= scene_d;
      scene_cnt_q   <= scene_cnt_d;
      distance_q    <= distance_d;
      road_y_prev_q <= road_y;
    end
  end

  assign road_clk_en = clk_en & run;
  assign scene       = scene_q;
  assign distance    = distance_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_road_ctrl.sv
// Directed bench for road_ctrl: vector table for the basic run cycle plus
// hand sequences for ramps, pause, scene wrap, saturation and reset.
module tb_road_ctrl;
  import road_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clk_en, frame_tick, start, crash, pause;
  logic [4:0]  road_y;
  logic        road_clk_en;
  logic [7:0]  speed;
  logic [1:0]  scene;
  logic [15:0] distance;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  road_ctrl #(.SCENE_DIST(16'd4)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .frame_tick  (frame_tick),
    .start       (start),
    .crash       (crash),
    .pause       (pause),
    .road_y      (road_y),
    .road_clk_en (road_clk_en),
    .speed       (speed),
    .scene       (scene),
    .distance    (distance),
    .state_o     (state_o)
  );

  typedef struct {
    logic        st, cr, pa, ft, ce;
    logic [4:0]  ry;
    logic [2:0]  e_state;
    logic [7:0]  e_speed;
    logic        e_rce;
    logic [15:0] e_dist;
    logic [1:0]  e_scene;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic st, cr, pa, ft, ce, input logic [4:0] ry,
                              input logic [2:0] es, input logic [7:0] esp, input logic erce,
                              input logic [15:0] ed, input logic [1:0] esc);
    vec_t v;
    v.st = st; v.cr = cr; v.pa = pa; v.ft = ft; v.ce = ce; v.ry = ry;
    v.e_state = es; v.e_speed = esp; v.e_rce = erce; v.e_dist = ed; v.e_scene = esc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic st, cr, pa, ft, ce, input logic [4:0] ry);
    start = st; crash = cr; pause = pa; frame_tick = ft; clk_en = ce; road_y = ry;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] ry;
    //          st cr pa ft ce ry  | state spd  rce dist scene
    vecs[0]  = mk(0, 0, 0, 0, 0, 0,  0, 200, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 1, 0,  1, 200, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 1, 0,  1, 200, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 1, 0,  1, 200, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 1, 0,  1, 200, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 1, 0,  1, 190, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 1,  1, 190, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 2,  1, 190, 1, 2, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1, 3,  1, 190, 1, 3, 0);
    vecs[9]  = mk(0, 0, 0, 0, 1, 4,  1, 190, 1, 4, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 4,  1, 190, 0, 4, 1);
    vecs[11] = mk(0, 0, 1, 1, 1, 4,  4, 190, 0, 4, 1);
    vecs[12] = mk(0, 1, 1, 0, 1, 5,  4, 190, 0, 4, 1);
    vecs[13] = mk(0, 0, 0, 0, 1, 5,  1, 190, 1, 4, 1);
    vecs[14] = mk(0, 1, 0, 1, 1, 5,  3, 190, 1, 4, 1);
    vecs[15] = mk(0, 0, 1, 1, 1, 5,  3, 190, 1, 4, 1);
    vecs[16] = mk(0, 0, 1, 1, 1, 5,  3, 190, 1, 4, 1);
    vecs[17] = mk(0, 0, 0, 1, 1, 5,  3, 190, 1, 4, 1);
    vecs[18] = mk(0, 0, 0, 1, 1, 5,  3, 200, 1, 4, 1);
    vecs[19] = mk(0, 0, 0, 0, 1, 5,  5, 200, 0, 4, 1);
    vecs[20] = mk(0, 0, 0, 0, 1, 6,  5, 200, 0, 4, 1);
    vecs[21] = mk(1, 0, 0, 0, 1, 6,  0, 200, 0, 0, 0);
    vecs[22] = mk(1, 0, 0, 0, 1, 6,  0, 200, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 1, 6,  0, 200, 0, 0, 0);
    vecs[24] = mk(1, 0, 0, 0, 1, 6,  1, 200, 1, 0, 0);

    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset.state", 32'(state_o), 32'd0);
    chk("reset.speed", 32'(speed), 32'd200);
    chk("reset.scene", 32'(scene), 32'd0);
    chk("reset.distance", 32'(distance), 32'd0);
    chk("reset.road_clk_en", 32'(road_clk_en), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].st, vecs[i].cr, vecs[i].pa, vecs[i].ft, vecs[i].ce, vecs[i].ry);
      chk($sformatf("v%0d.state", i), 32'(state_o), 32'(vecs[i].e_state));
      chk($sformatf("v%0d.speed", i), 32'(speed), 32'(vecs[i].e_speed));
      chk($sformatf("v%0d.road_clk_en", i), 32'(road_clk_en), 32'(vecs[i].e_rce));
      chk($sformatf("v%0d.distance", i), 32'(distance), 32'(vecs[i].e_dist));
      chk($sformatf("v%0d.scene", i), 32'(scene), 32'(vecs[i].e_scene));
    end

    // Full acceleration: 72 ticks, one 10-unit step every 4 ticks.
    for (int k = 1; k <= 72; k++) begin
      cyc(0, 0, 0, 1, 1, 6);
      if (k % 4 == 0) chk($sformatf("accel.speed.k%0d", k), 32'(speed), 32'(200 - 10 * (k / 4)));
    end
    cyc(0, 0, 0, 1, 1, 6);
    chk("accel.to_cruise", 32'(state_o), 32'd2);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1, 1, 6);
    chk("cruise.speed_hold", 32'(speed), 32'd20);
    chk("cruise.state_hold", 32'(state_o), 32'd2);

    // Pause in cruise with road_y moving and a crash pulse that must be ignored.
    for (int n = 0; n < 100; n++) begin
      ry = 5'((6 + n) % 32);
      cyc(0, (n == 50), 1, (n % 3 == 0), 1, ry);
      chk($sformatf("pause.road_clk_en.n%0d", n), 32'(road_clk_en), 32'd0);
    end
    chk("pause.state", 32'(state_o), 32'd4);
    chk("pause.distance", 32'(distance), 32'd0);
    cyc(0, 0, 0, 0, 1, ry);
    chk("unpause.state", 32'(state_o), 32'd2);
    chk("unpause.speed", 32'(speed), 32'd20);
    chk("unpause.road_clk_en", 32'(road_clk_en), 32'd1);

    // Scene wrap with a 4-step scene length.
    for (int k = 1; k <= 16; k++) begin
      ry = ry + 5'd1;
      cyc(0, 0, 0, 0, 1, ry);
      chk($sformatf("scene.distance.k%0d", k), 32'(distance), 32'(k));
      if (k % 4 == 0) chk($sformatf("scene.index.k%0d", k), 32'(scene), 32'((k / 4) % 4));
    end

    // Distance saturation from a preloaded value.
    force dut.distance_q = 16'hFFFD;
    #1;
    release dut.distance_q;
    ry = ry + 5'd1;
    cyc(0, 0, 0, 0, 1, ry);
    chk("sat.step1", 32'(distance), 32'hFFFE);
    ry = ry + 5'd1;
    cyc(0, 0, 0, 0, 1, ry);
    ry = ry + 5'd1;
    cyc(0, 0, 0, 0, 1, ry);
    chk("sat.step3", 32'(distance), 32'hFFFF);

    // Mid-brake reset.
    cyc(0, 1, 0, 0, 1, ry);
    chk("brake2.state", 32'(state_o), 32'd3);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1, 1, ry);
    chk("brake2.speed", 32'(speed), 32'd40);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 1, ry);
    rst = 1'b0;
    chk("midrst.state", 32'(state_o), 32'd0);
    chk("midrst.speed", 32'(speed), 32'd200);
    chk("midrst.distance", 32'(distance), 32'd0);
    chk("midrst.scene", 32'(scene), 32'd0);
    chk("midrst.road_clk_en", 32'(road_clk_en), 32'd0);

    // New run: crash at speed 120 with a coincident ramp tick, then brake out.
    cyc(0, 0, 0, 0, 1, ry);
    cyc(1, 0, 0, 0, 1, ry);
    chk("run3.state", 32'(state_o), 32'd1);
    for (int k = 0; k < 35; k++) cyc(0, 0, 0, 1, 1, ry);
    chk("run3.speed120", 32'(speed), 32'd120);
    cyc(0, 1, 0, 1, 1, ry);
    chk("crash.state", 32'(state_o), 32'd3);
    chk("crash.speed_held", 32'(speed), 32'd120);
    for (int k = 0; k < 32; k++) cyc(0, 0, 0, 1, 1, ry);
    chk("brake3.speed", 32'(speed), 32'd200);
    chk("brake3.state", 32'(state_o), 32'd3);
    cyc(0, 0, 0, 0, 1, ry);
    chk("stopped.state", 32'(state_o), 32'd5);
    chk("stopped.road_clk_en", 32'(road_clk_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/road_ctrl.md
Name: road_ctrl

Overview:
- Sequences the scrolling-road datapath for a run.
- Each frame it sets the road step divider (speed), gates the road's step enable, selects the scene, and accumulates distance travelled.
- Sits between game logic (start/crash/pause) and the road scroller. It drives the scroller's speed, scene and clk_en inputs and watches the scroller's Y output.

Parameters:
- SPEED_SLOW, 8'd200, divider value at launch and at end of braking (larger = slower)
- SPEED_FAST, 8'd20, minimum divider value (top speed)
- SPEED_STEP, 8'd10, divider change per ramp step
- RAMP_FRAMES, 4, frame ticks between ramp steps (1..15)
- SCENE_DIST, 16'd1000, road steps per scene

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  pixel/step enable from timing (same enable the scroller uses)
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  begin run (level; sampled in IDLE/STOPPED)
- crash  in  1  collision pulse
- pause  in  1  level; hold the road while high
- road_y  in  5  scroller Y position
- road_clk_en  out  1  gated step enable to scroller = clk_en & run
- speed  out  8  divider value to scroller
- scene  out  2  scene index to scroller and renderer
- distance  out  16  road steps this run, saturating at 16'hFFFF
- state_o  out  3  current FSM state (debug/UI)

Behaviour:
- Reset values: state IDLE, speed=SPEED_SLOW, scene=0, distance=0, road_clk_en=0, ramp counter=0.
- All updates are registered on posedge clk. Outputs are registered except road_clk_en, which is combinational from the registered run flag and clk_en.
- run flag = 1 in ACCEL, CRUISE, BRAKE; 0 in IDLE, PAUSED, STOPPED.
- FSM states and encodings: IDLE 0, ACCEL 1, CRUISE 2, BRAKE 3, PAUSED 4, STOPPED 5.
  - IDLE: start=1 -> ACCEL. Distance and scene cleared on entry.
  - ACCEL: speed reaches SPEED_FAST -> CRUISE.
  - CRUISE: holds speed.
  - ACCEL/CRUISE: crash -> BRAKE; otherwise pause=1 -> PAUSED.
  - PAUSED: remembers the prior state (ACCEL or CRUISE). Returns to it the cycle after pause=0. crash is ignored while paused.
  - BRAKE: speed reaches SPEED_SLOW -> STOPPED. pause is ignored.
  - STOPPED: start=1 -> IDLE. start must be low for at least one cycle in IDLE before a new run starts; IDLE requires a start rising edge.
- Priority when events coincide: rst > crash > pause > ramp step.
- Ramp counter:
  - Counts frame_tick pulses in ACCEL and BRAKE only.
  - When it reaches RAMP_FRAMES-1 on a frame_tick, it resets to 0 and a ramp step happens.
  - It is cleared on every state change.
- Ramp step arithmetic: 9-bit intermediate, saturating.
  - ACCEL: speed = max(speed - SPEED_STEP, SPEED_FAST).
  - BRAKE: speed = min(speed + SPEED_STEP, SPEED_SLOW).
  - No wrap-around is allowed.
- Distance:
  - road_y_prev is registered every cycle.
  - When run=1 and road_y != road_y_prev, distance increments by 1, saturating at FFFF.
  - A 16-bit scene counter increments in the same cycle.
  - When the scene counter reaches SCENE_DIST-1 and increments, it resets to 0 and scene increments mod 4 (3 -> 0).
- Mid-run reset returns to the reset values on the next edge, regardless of state.
- Scene changes take effect at the next road step. No glitch on the scene output: it only changes on clk edges.

Decomposition:
- Package road_pkg holds:
  - state encodings (IDLE..STOPPED)
  - SPEED_SLOW/FAST/STEP defaults
  - SCENE_COUNT=4
- Natural sub-module: speed_ramp.
  - Contains the ramp counter plus saturating add/sub.
  - Inputs: dir (accel/brake), enable, frame_tick, clear.
  - Output: speed, and at_limit flags (at_fast, at_slow).

Test Plan:
- Reset then idle: rst for 2 cycles -> speed=200, scene=0, distance=0, road_clk_en=0, state_o=0.
- Acceleration, defaults: start=1, then 72 frame_ticks -> speed steps 200,190,...,20, one step per 4 ticks. State goes ACCEL -> CRUISE when speed=20 (after 18 steps); speed holds at 20.
- Crash during ACCEL at speed=120 with frame_tick in the same cycle -> BRAKE with speed held at 120 (the ramp step is suppressed). Speed then rises 10 every 4 ticks to 200 -> STOPPED, road_clk_en=0.
- Pause in CRUISE: pause=1 for 100 cycles -> road_clk_en=0 and distance frozen. crash pulse while paused -> ignored. pause=0 -> back to CRUISE with speed still 20.
- Scene wrap, SCENE_DIST=4: drive 16 road_y changes while running -> scene goes 0,1,2,3,0 at distance 4,8,12,16.
- Distance saturation, plus restart and mid-run reset:
  - Preload distance near FFFF (force) and apply 3 steps -> distance=FFFF.
  - STOPPED then start -> IDLE clears distance to 0.
  - rst mid-BRAKE -> IDLE, speed=200.
